// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter that multiplexes instruction fetches and loads/stores onto
// a single-port memory with a one-cycle registered read, routing responses back.
module mem_port_arbiter #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rsp_valid,
  output logic [31:0] if_rdata,
  output logic        if_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [2:0]  d_funct3,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rsp_valid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        mem_write_mem,
  output logic [2:0]  mem_funct3,
  output logic [31:0] mem_write_address,
  output logic [31:0] mem_write_data,
  output logic [31:0] mem_read_address,
  input  logic [31:0] mem_read_data
);

  localparam int         DATA_W  = 32;
  localparam logic [2:0] F3_WORD = 3'b010;

  typedef enum logic {WHO_IF = 1'b0, WHO_D = 1'b1} who_e;

  function automatic logic fetch_misaligned(input logic [1:0] addr_lo);
    return addr_lo != 2'b00;
  endfunction

  // funct3[1:0] encodes the access size: 00 byte, 01 halfword, 10 word.
  function automatic logic data_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    case (funct3[1:0])
      2'b10:   mis = (addr_lo != 2'b00);
      2'b01:   mis = addr_lo[0];
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

  who_e              last_winner;
  logic              gnt_if_p0;
  logic              gnt_d_p0;
  logic              err_p0;
  logic              rd_p0;
  logic              wr_p0;
  logic [DATA_W-1:0] rd_addr_p0;
  logic [DATA_W-1:0] rd_addr_q;
  logic [DATA_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;

  logic              rsp_vld_p1;
  who_e              rsp_who_p1;
  logic              rsp_store_p1;
  logic              rsp_err_p1;
  logic              vld_if_p1;
  logic              vld_d_p1;

  // Stage p0: grant, alignment check and issue onto the memory port
  always_comb begin
    gnt_if_p0 = 1'b0;
    gnt_d_p0  = 1'b0;
    if (!reset) begin
      if (if_req && d_req) begin
        gnt_if_p0 = (last_winner == WHO_D);
        gnt_d_p0  = (last_winner == WHO_IF);
      end else begin
        gnt_if_p0 = if_req;
        gnt_d_p0  = d_req;
      end
    end
  end

  always_comb begin
    err_p0     = 1'b0;
    rd_p0      = 1'b0;
    wr_p0      = 1'b0;
    rd_addr_p0 = if_addr;
    if (gnt_if_p0) begin
      err_p0 = fetch_misaligned(if_addr[1:0]);
      rd_p0  = !err_p0;
    end else if (gnt_d_p0) begin
      err_p0     = data_misaligned(d_funct3, d_addr[1:0]);
      rd_p0      = !err_p0 && !d_we;
      wr_p0      = !err_p0 && d_we;
      rd_addr_p0 = d_addr;
    end
  end

  assign if_gnt            = gnt_if_p0;
  assign d_gnt             = gnt_d_p0;
  assign mem_write_mem     = wr_p0;
  assign mem_funct3        = (wr_p0 || (rd_p0 && gnt_d_p0)) ? d_funct3 : F3_WORD;
  assign mem_read_address  = reset ? RESET_PC : (rd_p0 ? rd_addr_p0 : rd_addr_q);
  assign mem_write_address = wr_p0 ? d_addr : wr_addr_q;
  assign mem_write_data    = wr_p0 ? d_wdata : wr_data_q;

  // Stage p0 -> p1: control state and response tag
  always_ff @(posedge clk) begin
    if (reset) begin
      last_winner <= WHO_D;
      rsp_vld_p1  <= 1'b0;
      rd_addr_q   <= RESET_PC;
    end else begin
      if (gnt_if_p0) begin
        last_winner <= WHO_IF;
      end else if (gnt_d_p0) begin
        last_winner <= WHO_D;
      end
      rsp_vld_p1 <= gnt_if_p0 || gnt_d_p0;
      if (rd_p0) begin
        rd_addr_q <= rd_addr_p0;
      end
    end
  end

  always_ff @(posedge clk) begin
    rsp_who_p1   <= gnt_d_p0 ? WHO_D : WHO_IF;
    rsp_store_p1 <= gnt_d_p0 && d_we;
    rsp_err_p1   <= err_p0;
    if (wr_p0) begin
      wr_addr_q <= d_addr;
      wr_data_q <= d_wdata;
    end
  end

  // Stage p1: route the response; reset suppresses a response still in flight
  assign vld_if_p1    = rsp_vld_p1 && !reset && (rsp_who_p1 == WHO_IF);
  assign vld_d_p1     = rsp_vld_p1 && !reset && (rsp_who_p1 == WHO_D);
  assign if_rsp_valid = vld_if_p1;
  assign if_err       = vld_if_p1 && rsp_err_p1;
  assign if_rdata     = (vld_if_p1 && !rsp_err_p1) ? mem_read_data : '0;
  assign d_rsp_valid  = vld_d_p1;
  assign d_err        = vld_d_p1 && rsp_err_p1;
  assign d_rdata      = (vld_d_p1 && !rsp_store_p1 && !rsp_err_p1) ? mem_read_data : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a behavioural 8 kB memory with millis/led MMIO,
// directed scenarios and a randomized run against a transaction-level model.
module tb_mem_port_arbiter;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_gnt;
  logic        if_rsp_valid;
  logic [31:0] if_rdata;
  logic        if_err;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [2:0]  d_funct3 = 3'b010;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic        d_gnt;
  logic        d_rsp_valid;
  logic [31:0] d_rdata;
  logic        d_err;
  logic        mem_write_mem;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_write_address;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_address;
  logic [31:0] mem_read_data;

  int checks = 0;
  int fails = 0;
  logic [31:0] last_rd;

  mem_port_arbiter #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rsp_valid(if_rsp_valid), .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_funct3(d_funct3), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rsp_valid(d_rsp_valid),
    .d_rdata(d_rdata), .d_err(d_err),
    .mem_write_mem(mem_write_mem), .mem_funct3(mem_funct3),
    .mem_write_address(mem_write_address), .mem_write_data(mem_write_data),
    .mem_read_address(mem_read_address), .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  // Memory model: unwritten words hold an address-derived pattern.
  bit [31:0] ram [0:2047];
  bit        wr_mask [0:2047];
  bit [31:0] millis;
  bit [31:0] led_reg;
  int        presc = 0;
  logic      led;
  assign led = led_reg[31];

  function automatic logic [31:0] word_at(input logic [31:0] a);
    if ({a[31:2], 2'b00} == 32'hFFFF_FFF8) return millis;
    if ({a[31:2], 2'b00} == 32'hFFFF_FFFC) return led_reg;
    if (wr_mask[a[12:2]]) return ram[a[12:2]];
    return 32'h9E37_79B9 * ({21'h0, a[12:2]} + 32'd1);
  endfunction

  function automatic logic [31:0] load_val(input logic [31:0] a, input logic [2:0] f3);
    logic [31:0] sh;
    sh = word_at(a) >> {a[1:0], 3'b000};
    case (f3)
      3'b000:  return {{24{sh[7]}}, sh[7:0]};
      3'b100:  return {24'h0, sh[7:0]};
      3'b001:  return {{16{sh[15]}}, sh[15:0]};
      3'b101:  return {16'h0, sh[15:0]};
      default: return word_at(a);
    endcase
  endfunction

  function automatic bit [31:0] merge_store(input bit [31:0] old, input logic [1:0] off,
                                            input logic [2:0] f3, input logic [31:0] wd);
    bit [31:0] r;
    r = old;
    case (f3[1:0])
      2'b00:   r[{off, 3'b000} +: 8] = wd[7:0];
      2'b01:   r[{off[1], 4'b0000} +: 16] = wd[15:0];
      default: r = wd;
    endcase
    return r;
  endfunction

  // Millis advances every 12000 clocks.
  always @(posedge clk) begin
    mem_read_data <= load_val(mem_read_address, mem_funct3);
    if (presc == 11999) begin
      presc  <= 0;
      millis <= millis + 32'd1;
    end else begin
      presc <= presc + 1;
    end
    if (mem_write_mem === 1'b1) begin
      if ({mem_write_address[31:2], 2'b00} == 32'hFFFF_FFFC) begin
        led_reg <= merge_store(led_reg, mem_write_address[1:0], mem_funct3, mem_write_data);
      end else if (mem_write_address[31:13] == 19'h0) begin
        ram[mem_write_address[12:2]] <= merge_store(word_at(mem_write_address),
                                        mem_write_address[1:0], mem_funct3, mem_write_data);
        wr_mask[mem_write_address[12:2]] <= 1'b1;
      end
    end
  end

  task automatic apply_reset();
    reset = 1'b1; if_req = 1'b0; d_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    last_rd = RESET_PC;
  endtask

  task automatic test_reset();
    logic [31:0] exp;
    reset = 1'b1; if_req = 1'b1; if_addr = 32'h40;
    d_req = 1'b1; d_we = 1'b1; d_funct3 = 3'b010; d_addr = 32'h100; d_wdata = 32'h1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (mem_read_address !== RESET_PC || mem_funct3 !== 3'b010) begin
        fails++;
        $display("FAIL reset_port c%0d: read_address=%h funct3=%b, want %h 010", i, mem_read_address, mem_funct3, RESET_PC);
      end
      checks++;
      if ({if_gnt, d_gnt, if_rsp_valid, d_rsp_valid, if_err, d_err, mem_write_mem} !== 7'b0) begin
        fails++;
        $display("FAIL reset_quiet c%0d: gnt/rsp/err/wr=%b, want 0000000", i,
                 {if_gnt, d_gnt, if_rsp_valid, d_rsp_valid, if_err, d_err, mem_write_mem});
      end
      @(posedge clk); #1;
    end
    reset = 1'b0; if_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
    checks++;
    if (if_rsp_valid !== 1'b0 || d_rsp_valid !== 1'b0 || mem_read_address !== RESET_PC) begin
      fails++;
      $display("FAIL post_reset: if_rsp=%b d_rsp=%b read_address=%h, want 0 0 %h", if_rsp_valid, d_rsp_valid, mem_read_address, RESET_PC);
    end
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h4;
    exp = word_at(32'h4);
    @(negedge clk);
    checks++;
    if (if_gnt !== 1'b1 || d_gnt !== 1'b0 || mem_read_address !== 32'h4 || mem_funct3 !== 3'b010 || mem_write_mem !== 1'b0) begin
      fails++;
      $display("FAIL first_fetch_issue: if_gnt=%b d_gnt=%b addr=%h f3=%b wr=%b, want 1 0 4 010 0", if_gnt, d_gnt, mem_read_address, mem_funct3, mem_write_mem);
    end
    @(posedge clk); #1;
    if_req = 1'b0;
    @(negedge clk);
    checks++;
    if (if_rsp_valid !== 1'b1 || if_rdata !== exp || if_err !== 1'b0 || d_rsp_valid !== 1'b0) begin
      fails++;
      $display("FAIL first_fetch_rsp: valid=%b rdata=%h err=%b, want 1 %h 0", if_rsp_valid, if_rdata, if_err, exp);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_alternate();
    bit          who [4];
    logic [31:0] exp_if, exp_d;
    who = '{1'b0, 1'b1, 1'b0, 1'b1};
    apply_reset();
    if_req = 1'b1; if_addr = 32'h10;
    d_req = 1'b1; d_we = 1'b0; d_funct3 = 3'b010; d_addr = 32'h200;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) begin if_req = 1'b0; d_req = 1'b0; end
      @(negedge clk);
      if (i > 0) begin
        checks++;
        if (!who[i-1] ? (if_rsp_valid !== 1'b1 || if_rdata !== exp_if || d_rsp_valid !== 1'b0)
                      : (d_rsp_valid !== 1'b1 || d_rdata !== exp_d || if_rsp_valid !== 1'b0)) begin
          fails++;
          $display("FAIL alt_rsp %0d: if_rsp=%b if_rdata=%h d_rsp=%b d_rdata=%h, want %s response (if %h / d %h)",
                   i - 1, if_rsp_valid, if_rdata, d_rsp_valid, d_rdata, who[i-1] ? "data" : "fetch", exp_if, exp_d);
        end
      end
      if (i < 4) begin
        checks++;
        if (if_gnt !== !who[i] || d_gnt !== who[i]) begin
          fails++;
          $display("FAIL alt_gnt %0d: if_gnt=%b d_gnt=%b, want %b %b", i, if_gnt, d_gnt, !who[i], who[i]);
        end
        exp_if = word_at(32'h10);
        exp_d  = load_val(32'h200, 3'b010);
      end
      @(posedge clk); #1;
    end
    last_rd = 32'h200;
  endtask

  task automatic test_store_load();
    logic [2:0]  f3 [2];
    logic [31:0] want [2];
    f3 = '{3'b100, 3'b000};
    want = '{32'h0000_00AB, 32'hFFFF_FFAB};  // 0xAB has bit 7 set, so LB sign-extends
    d_req = 1'b1; d_we = 1'b1; d_funct3 = 3'b000; d_addr = 32'h103; d_wdata = 32'hAB;
    @(negedge clk);
    checks++;
    if (d_gnt !== 1'b1 || mem_write_mem !== 1'b1 || mem_funct3 !== 3'b000 || mem_write_address !== 32'h103 || mem_write_data !== 32'hAB) begin
      fails++;
      $display("FAIL sb_issue: gnt=%b wr=%b f3=%b waddr=%h wdata=%h, want 1 1 000 103 ab", d_gnt, mem_write_mem, mem_funct3, mem_write_address, mem_write_data);
    end
    @(posedge clk); #1;
    d_req = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_write_mem !== 1'b0 || d_rsp_valid !== 1'b1 || d_rdata !== 32'h0 || d_err !== 1'b0) begin
      fails++;
      $display("FAIL sb_rsp: wr=%b rsp=%b rdata=%h err=%b, want 0 1 0 0", mem_write_mem, d_rsp_valid, d_rdata, d_err);
    end
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      d_req = 1'b1; d_we = 1'b0; d_funct3 = f3[i]; d_addr = 32'h103;
      @(negedge clk);
      checks++;
      if (d_gnt !== 1'b1 || mem_read_address !== 32'h103 || mem_funct3 !== f3[i] || mem_write_mem !== 1'b0) begin
        fails++;
        $display("FAIL byte_load_issue %0d: gnt=%b addr=%h f3=%b wr=%b, want 1 103 %b 0", i, d_gnt, mem_read_address, mem_funct3, mem_write_mem, f3[i]);
      end
      @(posedge clk); #1;
      d_req = 1'b0;
      @(negedge clk);
      checks++;
      if (d_rsp_valid !== 1'b1 || d_rdata !== want[i] || d_err !== 1'b0) begin
        fails++;
        $display("FAIL byte_load_rsp %0d: rsp=%b rdata=%h err=%b, want 1 %h 0", i, d_rsp_valid, d_rdata, d_err, want[i]);
      end
    end
    @(posedge clk); #1;
    last_rd = 32'h103;
  endtask

  task automatic test_misaligned();
    bit          fetch [3];
    bit          we [3];
    logic [2:0]  f3 [3];
    logic [31:0] a [3];
    fetch = '{1'b0, 1'b0, 1'b1};
    we    = '{1'b0, 1'b1, 1'b0};
    f3    = '{3'b010, 3'b001, 3'b010};
    a     = '{32'h102, 32'h101, 32'h6};
    for (int i = 0; i < 3; i++) begin
      if (fetch[i]) begin
        if_req = 1'b1; if_addr = a[i];
      end else begin
        d_req = 1'b1; d_we = we[i]; d_funct3 = f3[i]; d_addr = a[i]; d_wdata = 32'h5A5A_5A5A;
      end
      @(negedge clk);
      checks++;
      if (if_gnt !== fetch[i] || d_gnt !== !fetch[i] || mem_write_mem !== 1'b0 ||
          mem_read_address !== last_rd || mem_funct3 !== 3'b010) begin
        fails++;
        $display("FAIL misalign_issue %0d: if_gnt=%b d_gnt=%b wr=%b addr=%h f3=%b, want %b %b 0 %h 010",
                 i, if_gnt, d_gnt, mem_write_mem, mem_read_address, mem_funct3, fetch[i], !fetch[i], last_rd);
      end
      @(posedge clk); #1;
      if_req = 1'b0; d_req = 1'b0;
      @(negedge clk);
      checks++;
      if (fetch[i] ? (if_rsp_valid !== 1'b1 || if_err !== 1'b1 || if_rdata !== 32'h0 || d_rsp_valid !== 1'b0)
                   : (d_rsp_valid !== 1'b1 || d_err !== 1'b1 || d_rdata !== 32'h0 || if_rsp_valid !== 1'b0)) begin
        fails++;
        $display("FAIL misalign_rsp %0d: if rsp/err/rdata=%b/%b/%h d rsp/err/rdata=%b/%b/%h", i,
                 if_rsp_valid, if_err, if_rdata, d_rsp_valid, d_err, d_rdata);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mmio();
    logic [31:0] exp1;
    d_req = 1'b1; d_we = 1'b0; d_funct3 = 3'b010; d_addr = 32'hFFFF_FFF8;
    @(negedge clk);
    exp1 = word_at(32'hFFFF_FFF8);
    @(posedge clk); #1;
    d_req = 1'b0;
    @(negedge clk);
    checks++;
    if (d_rsp_valid !== 1'b1 || d_rdata !== exp1) begin
      fails++;
      $display("FAIL millis_first: rsp=%b rdata=%h, want 1 %h", d_rsp_valid, d_rdata, exp1);
    end
    repeat (11999) @(posedge clk);
    #1;
    d_req = 1'b1;
    @(posedge clk); #1;
    d_req = 1'b0;
    @(negedge clk);
    checks++;
    if (d_rsp_valid !== 1'b1 || d_rdata !== exp1 + 32'd1) begin
      fails++;
      $display("FAIL millis_second: rsp=%b rdata=%h, want 1 %h", d_rsp_valid, d_rdata, exp1 + 32'd1);
    end
    @(posedge clk); #1;
    d_req = 1'b1; d_we = 1'b1; d_funct3 = 3'b010; d_addr = 32'hFFFF_FFFC; d_wdata = 32'hFF00_0000;
    @(negedge clk);
    checks++;
    if (mem_write_mem !== 1'b1 || mem_write_address !== 32'hFFFF_FFFC || mem_write_data !== 32'hFF00_0000) begin
      fails++;
      $display("FAIL led_store: wr=%b waddr=%h wdata=%h, want 1 fffffffc ff000000", mem_write_mem, mem_write_address, mem_write_data);
    end
    @(posedge clk); #1;
    d_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (led !== 1'b1) begin
        fails++;
        $display("FAIL led_high %0d: led=%b, want 1", i, led);
      end
      repeat (10) @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset_inflight();
    d_req = 1'b1; d_we = 1'b0; d_funct3 = 3'b010; d_addr = 32'h200;
    @(negedge clk);
    checks++;
    if (d_gnt !== 1'b1) begin
      fails++;
      $display("FAIL inflight_gnt: d_gnt=%b, want 1", d_gnt);
    end
    @(posedge clk); #1;
    reset = 1'b1; d_req = 1'b0;
    @(negedge clk);
    checks++;
    if (d_rsp_valid !== 1'b0 || if_rsp_valid !== 1'b0 || mem_read_address !== RESET_PC) begin
      fails++;
      $display("FAIL inflight_drop: d_rsp=%b if_rsp=%b addr=%h, want 0 0 %h", d_rsp_valid, if_rsp_valid, mem_read_address, RESET_PC);
    end
    @(posedge clk); #1;
    reset = 1'b0; last_rd = RESET_PC;
    if_req = 1'b1; if_addr = 32'h20; d_req = 1'b1;
    @(negedge clk);
    checks++;
    if (d_rsp_valid !== 1'b0 || if_rsp_valid !== 1'b0 || if_gnt !== 1'b1 || d_gnt !== 1'b0) begin
      fails++;
      $display("FAIL restart: d_rsp=%b if_rsp=%b if_gnt=%b d_gnt=%b, want 0 0 1 0", d_rsp_valid, if_rsp_valid, if_gnt, d_gnt);
    end
    @(posedge clk); #1;
    if_req = 1'b0;
    @(negedge clk);
    checks++;
    if (d_gnt !== 1'b1 || if_rsp_valid !== 1'b1 || d_rsp_valid !== 1'b0) begin
      fails++;
      $display("FAIL restart_next: d_gnt=%b if_rsp=%b d_rsp=%b, want 1 1 0", d_gnt, if_rsp_valid, d_rsp_valid);
    end
    @(posedge clk); #1;
    d_req = 1'b0;
  endtask

  task automatic test_random();
    logic [2:0]  lf3 [5];
    logic [2:0]  sf3 [3];
    int          last_who, w, pwho;
    bit          pv, perr, e, rdop, wrop, if_pend, d_pend, ok;
    logic [31:0] prd, ra, exp_ra;
    logic [2:0]  rf, exp_f;
    lf3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    sf3 = '{3'b000, 3'b001, 3'b010};
    apply_reset();
    last_who = 1; pv = 1'b0; pwho = 0; perr = 1'b0; prd = '0;
    if_pend = 1'b0; d_pend = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (!if_pend) begin
        if_req  = ($urandom_range(0, 3) != 0);
        if_addr = 32'h300 + (32'($urandom_range(0, 63)) << 2);
        if ($urandom_range(0, 7) == 0) if_addr = if_addr + 32'($urandom_range(1, 3));
      end
      if (!d_pend) begin
        d_req   = ($urandom_range(0, 3) != 0);
        d_we    = ($urandom_range(0, 2) == 0);
        d_funct3 = d_we ? sf3[$urandom_range(0, 2)] : lf3[$urandom_range(0, 4)];
        d_addr  = 32'h300 + 32'($urandom_range(0, 255));
        d_wdata = $urandom;
      end
      @(negedge clk);
      w = -1;
      if (if_req && d_req) w = (last_who == 1) ? 0 : 1;
      else if (if_req) w = 0;
      else if (d_req) w = 1;
      checks++;
      if (if_gnt !== (w == 0) || d_gnt !== (w == 1)) begin
        fails++;
        $display("FAIL rnd_gnt c%0d: if_gnt=%b d_gnt=%b, want %b %b", c, if_gnt, d_gnt, w == 0, w == 1);
      end
      if (!pv)            ok = (if_rsp_valid === 1'b0 && d_rsp_valid === 1'b0);
      else if (pwho == 0) ok = (if_rsp_valid === 1'b1 && d_rsp_valid === 1'b0 && if_err === perr && if_rdata === prd);
      else                ok = (d_rsp_valid === 1'b1 && if_rsp_valid === 1'b0 && d_err === perr && d_rdata === prd);
      checks++;
      if (!ok) begin
        fails++;
        $display("FAIL rnd_rsp c%0d: if %b/%b/%h d %b/%b/%h, want pending=%b who=%0d err=%b rdata=%h",
                 c, if_rsp_valid, if_err, if_rdata, d_rsp_valid, d_err, d_rdata, pv, pwho, perr, prd);
      end
      e = 1'b0;
      if (w == 0) e = (if_addr % 4 != 0);
      else if (w == 1 && d_funct3[1:0] == 2'b10) e = (d_addr % 4 != 0);
      else if (w == 1 && d_funct3[1:0] == 2'b01) e = (d_addr % 2 != 0);
      wrop = (w == 1) && d_we && !e;
      rdop = (w >= 0) && !e && !wrop && !((w == 1) && d_we);
      ra   = (w == 0) ? if_addr : d_addr;
      rf   = (w == 0) ? 3'b010 : d_funct3;
      checks++;
      if (mem_write_mem !== wrop) begin
        fails++;
        $display("FAIL rnd_wr c%0d: write_mem=%b, want %b", c, mem_write_mem, wrop);
      end
      if (wrop) begin
        checks++;
        if (mem_write_address !== d_addr || mem_write_data !== d_wdata || mem_funct3 !== d_funct3) begin
          fails++;
          $display("FAIL rnd_store c%0d: waddr=%h wdata=%h f3=%b, want %h %h %b", c, mem_write_address, mem_write_data, mem_funct3, d_addr, d_wdata, d_funct3);
        end
      end else begin
        exp_ra = rdop ? ra : last_rd;
        exp_f  = rdop ? rf : 3'b010;
        checks++;
        if (mem_read_address !== exp_ra || mem_funct3 !== exp_f) begin
          fails++;
          $display("FAIL rnd_read c%0d: addr=%h f3=%b, want %h %b", c, mem_read_address, mem_funct3, exp_ra, exp_f);
        end
      end
      pv   = (w >= 0);
      pwho = w;
      perr = e;
      prd  = rdop ? load_val(ra, rf) : 32'h0;
      if (rdop) last_rd = ra;
      if (w >= 0) last_who = w;
      if_pend = if_req && (w != 0);
      d_pend  = d_req && (w != 1);
      @(posedge clk); #1;
    end
    if_req = 1'b0; d_req = 1'b0;
  endtask

  initial begin
    last_rd = RESET_PC;
    test_reset();
    test_alternate();
    test_store_load();
    test_misaligned();
    test_mmio();
    test_reset_inflight();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
